fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage for the RV32I core; sits directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address. Instruction memory returns the word combinationally in the same cycle.
- Registers the returned instruction into the IF/ID pipeline register, with a valid/ready handshake toward decode and a redirect/flush path from execute (branches, JAL, JALR).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0040, PC loaded on misaligned redirect (only used when FETCH_MISALIGN_TRAP_EN is defined).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- fetch_en  input  1  1 = fetch permitted; 0 = hold PC and issue no new instructions.
- imem_addr  output  32  byte address to instruction memory; equals PC register.
- imem_inst  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  execute requests a control-flow change this cycle.
- redirect_target  input  32  byte address of the new PC.
- id_ready  input  1  decode can accept the IF/ID contents this cycle.
- if_id_valid  output  1  IF/ID register holds a live instruction.
- if_id_inst  output  32  fetched instruction.
- if_id_pc  output  32  PC of if_id_inst.
- if_id_pc4  output  32  if_id_pc + 4.
- misalign_trap  output  1  (macro only) one-cycle pulse on misaligned redirect.
- trap_pc  output  32  (macro only) offending redirect target.

Behaviour:
- Reset (rst=1 at edge, overrides every other input):
  - PC <= RESET_PC.
  - if_id_valid <= 0, if_id_inst <= NOP (32'h0000_0013), if_id_pc <= 0, if_id_pc4 <= 0.
  - misalign_trap <= 0, trap_pc <= 0.
- imem_addr = PC register, combinational, no added latency. Fetch-to-IF/ID latency is 1 cycle.
- Transfer to decode occurs when if_id_valid && id_ready.
- Load condition: load = fetch_en && (!if_id_valid || id_ready). On load:
  - if_id_inst <= imem_inst, if_id_pc <= PC, if_id_pc4 <= PC+4, if_id_valid <= 1.
  - PC <= PC+4.
- Stall: if_id_valid && !id_ready → PC and all IF/ID fields hold unchanged.
- Drain: !fetch_en && id_ready → if_id_valid <= 0 and PC holds. With !fetch_en && !id_ready, everything holds.
- Redirect (priority over stall and load, below reset):
  - PC <= {redirect_target[31:2], 2'b00}.
  - if_id_valid <= 0, if_id_inst <= NOP; the wrong-path instruction is discarded.
  - The next cycle fetches the target (if fetch_en).
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Redirect during stall: flush still occurs and the stalled instruction is lost. Execute must account for this.
- Redirect with fetch_en=0: PC updates and no fetch occurs until fetch_en returns.
- PC[1:0] is always 2'b00.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined, with redirect_valid && redirect_target[1:0] != 0:
  - PC <= TRAP_VEC, IF/ID flushed.
  - misalign_trap = 1 for exactly one cycle, trap_pc <= redirect_target.
  - Aligned redirects behave normally.
- Not defined: low two bits are silently cleared, misalign_trap and trap_pc ports are absent, and TRAP_VEC is unused.

Decomposition:
- Package fetch_pkg holds:
  - XLEN=32 and the NOP constant 32'h0000_0013.
  - Packed struct if_id_t {valid, inst, pc, pc4} and the RESET_PC default.
- One natural sub-module, fetch_pc_reg: PC register, next-PC mux (reset / trap / redirect / +4 / hold), and alignment logic.
- fetch_stage instantiates fetch_pc_reg and holds the IF/ID register and handshake.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory word k = 32'h1000_0000+k:
  - imem_addr sequence 0,4,8,12.
  - if_id_inst 32'h1000_0000, 32'h1000_0001, … one cycle after each address.
  - if_id_pc4 = if_id_pc+4.
- Stall: id_ready=0 for 3 cycles while if_id_pc=8 → PC stays 12, IF/ID stays pc=8. On release, the next transfer is pc=12 with no skip or duplicate.
- Redirect to 32'h0000_0024 while if_id_pc=16 valid:
  - Next cycle if_id_valid=0, if_id_inst=NOP, imem_addr=32'h24.
  - The following cycle if_id_pc=32'h24.
- Redirect and stall same cycle → flush wins; imem_addr = target next cycle.
- PC at 32'hFFFF_FFFC with load → next imem_addr=0. rst asserted in the same cycle as a redirect → PC=RESET_PC, if_id_valid=0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 32'h0000_0026:
  - misalign_trap pulses 1 cycle, trap_pc=32'h26, imem_addr=TRAP_VEC.
- Without the macro, redirect to 32'h0000_0026 → imem_addr=32'h24.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and IF/ID record for the fetch stage
package fetch_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0040;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with next-PC selection; FETCH_MISALIGN_TRAP_EN adds trap vectoring
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        trap_redirect,
`endif
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned    = |redirect_target[1:0];
   assign trap_redirect = redirect_valid && misaligned;
`else
   // Low target bits are dropped by the alignment mask below.
   logic unused_low_bits;
   assign unused_low_bits = ^redirect_target[1:0];
`endif

   always_comb begin
      pc_next = pc_q;
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misaligned)
            pc_next = {TRAP_VEC[31:2], 2'b00};
         else
            pc_next = {redirect_target[31:2], 2'b00};
`else
         pc_next = {redirect_target[31:2], 2'b00};
`endif
      end else if (load) begin
         pc_next = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         pc_q <= {RESET_PC[31:2], 2'b00};
      else
         pc_q <= pc_next;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, IF/ID register, decode handshake; FETCH_MISALIGN_TRAP_EN adds misalign trap
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        id_ready,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misalign_trap,
   output logic [31:0] trap_pc
`endif
);

   if_id_t      if_id_q;
   logic [31:0] pc;
   logic        load;

   assign load = fetch_en && (!if_id_q.valid || id_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_redirect;

   fetch_pc_reg #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) u_pc (
      .clk             (clk),
      .rst             (rst),
      .load            (load),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_redirect   (trap_redirect),
      .pc              (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_trap <= 1'b0;
         trap_pc       <= 32'h0;
      end else begin
         misalign_trap <= trap_redirect;
         if (trap_redirect)
            trap_pc <= redirect_target;
      end
   end
`else
   logic unused_trap_vec;
   assign unused_trap_vec = ^TRAP_VEC;

   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk             (clk),
      .rst             (rst),
      .load            (load),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc              (pc)
   );
`endif

   // Redirect flushes even a stalled instruction; execute re-issues the path.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_q <= '{valid: 1'b0, inst: NOP, pc: 32'h0, pc4: 32'h0};
      end else if (redirect_valid) begin
         if_id_q.valid <= 1'b0;
         if_id_q.inst  <= NOP;
      end else if (load) begin
         if_id_q.valid <= 1'b1;
         if_id_q.inst  <= imem_inst;
         if_id_q.pc    <= pc;
         if_id_q.pc4   <= pc + 32'd4;
      end else if (!fetch_en && id_ready) begin
         if_id_q.valid <= 1'b0;
      end
   end

   assign imem_addr   = pc;
   assign if_id_valid = if_id_q.valid;
   assign if_id_inst  = if_id_q.inst;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_pc4   = if_id_q.pc4;

endmodule
